// File: rtl/riscv.sv
// riscv: 5-stage pipelined RV32I subset core with forwarding, load-use stall and EX-stage branch resolution
module imem (
  input  logic        clk,
  input  logic        we,
  input  logic [6:0]  wa,
  input  logic [31:0] wd,
  input  logic [6:0]  ra,
  output logic [31:0] rd
);
  logic [31:0] Inst_mem [0:127];
  always_ff @(posedge clk) if (we) Inst_mem[wa] <= wd;
  assign rd = Inst_mem[ra];
endmodule

module datapath (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] wb_data,
  output logic [31:0] address,
  output logic [8:0]  newadd,
  output logic        j,
  output logic        br,
  output logic        z,
  output logic        b
);
  typedef struct packed {
    logic v, rw, mr, mw, br, jal, jalr, lui, src, lt, inv;
    logic [3:0] alu;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] pc, a, b, imm;
  } idex_t;
  typedef struct packed {
    logic rw, mr, mw;
    logic [4:0] rd;
    logic [31:0] res, sd;
  } exm_t;
  typedef struct packed {
    logic rw;
    logic [4:0] rd;
    logic [31:0] val;
  } wb_t;
  logic [31:0] pc, ir_pc, ir, inst;
  logic [31:0] rf [0:31];
  logic [31:0] dm [0:255];
  idex_t dec, idex;
  exm_t exm;
  wb_t wb;
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rs1, rs2;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, use1, use2;
  logic stall, flush, take, wb_we;
  logic [31:0] fa, fb, opa, opb, alu_y, target, npc;
  imem instr_mem (.clk(clk), .we(1'b0), .wa(7'd0), .wd(32'd0), .ra(pc[8:2]), .rd(inst));
  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign is_r = op == 7'b0110011;
  assign is_i = op == 7'b0010011;
  assign is_ld = op == 7'b0000011 && f3 == 3'b010;
  assign is_st = op == 7'b0100011 && f3 == 3'b010;
  assign is_br = op == 7'b1100011 && !f3[1];
  assign is_jal = op == 7'b1101111;
  assign is_jalr = op == 7'b1100111 && f3 == 3'b000;
  assign is_lui = op == 7'b0110111;
  assign use1 = is_r | is_i | is_ld | is_st | is_br | is_jalr;
  assign use2 = is_r | is_st | is_br;
  assign wb_we = wb.rw && wb.rd != 5'd0;
  always_comb begin
    dec = '0;
    dec.v = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui;
    dec.rw = is_r | is_i | is_ld | is_jal | is_jalr | is_lui;
    dec.mr = is_ld;
    dec.mw = is_st;
    dec.br = is_br;
    dec.jal = is_jal;
    dec.jalr = is_jalr;
    dec.lui = is_lui;
    dec.src = !is_r && !is_br;
    dec.lt = f3[2];
    dec.inv = f3[0];
    dec.alu = is_r ? {ir[30], f3} : is_i ? {f3 == 3'b101 && ir[30], f3} : is_br ? 4'b1000 : 4'b0000;
    dec.rs1 = rs1;
    dec.rs2 = rs2;
    dec.rd = ir[11:7];
    dec.pc = ir_pc;
    dec.a = rs1 == 5'd0 ? '0 : wb_we && wb.rd == rs1 ? wb.val : rf[rs1];
    dec.b = rs2 == 5'd0 ? '0 : wb_we && wb.rd == rs2 ? wb.val : rf[rs2];
    dec.imm = is_st ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
              is_br ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
              is_jal ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
              is_lui ? {ir[31:12], 12'b0} : {{20{ir[31]}}, ir[31:20]};
  end
  assign stall = idex.mr && idex.rd != 5'd0 && ((use1 && idex.rd == rs1) || (use2 && idex.rd == rs2));
  assign fa = exm.rw && exm.rd != 5'd0 && exm.rd == idex.rs1 ? exm.res : wb_we && wb.rd == idex.rs1 ? wb.val : idex.a;
  assign fb = exm.rw && exm.rd != 5'd0 && exm.rd == idex.rs2 ? exm.res : wb_we && wb.rd == idex.rs2 ? wb.val : idex.b;
  assign opa = idex.lui ? '0 : fa;
  assign opb = idex.src ? idex.imm : fb;
  always_comb
    case (idex.alu)
      4'b1000: alu_y = opa - opb;
      4'b0001: alu_y = opa << opb[4:0];
      4'b0010: alu_y = {31'b0, $signed(opa) < $signed(opb)};
      4'b0011: alu_y = {31'b0, opa < opb};
      4'b0100: alu_y = opa ^ opb;
      4'b0101: alu_y = opa >> opb[4:0];
      4'b1101: alu_y = $signed(opa) >>> opb[4:0];
      4'b0110: alu_y = opa | opb;
      4'b0111: alu_y = opa & opb;
      default: alu_y = opa + opb;
    endcase
  assign take = idex.br && ((idex.lt ? $signed(fa) < $signed(fb) : fa == fb) ^ idex.inv);
  assign flush = take || idex.jal || idex.jalr;
  assign target = idex.jalr ? (fa + idex.imm) & ~32'd1 : idex.pc + idex.imm;
  assign npc = flush ? target : stall ? pc : pc + 32'd4;
  assign address = pc;
  assign newadd = rst ? 9'd0 : npc[8:0];
  assign j = idex.jal || idex.jalr;
  assign br = idex.br;
  assign z = idex.v && alu_y == '0;
  assign b = take;
  assign wb_data = wb_we ? wb.val : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= '0;
      ir_pc <= '0;
      ir <= '0;
      idex <= '0;
      exm <= '0;
      wb <= '0;
    end else begin
      pc <= npc;
      if (flush) ir <= '0;
      else if (!stall) begin
        ir <= inst;
        ir_pc <= pc;
      end
      idex <= flush || stall ? '0 : dec;
      exm <= '{rw: idex.rw, mr: idex.mr, mw: idex.mw, rd: idex.rd,
               res: (idex.jal || idex.jalr) ? idex.pc + 32'd4 : alu_y, sd: fb};
      wb <= '{rw: exm.rw, rd: exm.rd, val: exm.mr ? dm[exm.res[9:2]] : exm.res};
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (wb_we) rf[wb.rd] <= wb.val;
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 256; i++) dm[i] <= '0;
    else if (exm.mw) dm[exm.res[9:2]] <= exm.sd;
endmodule

module riscv (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] WB_Data,
  output logic [31:0] Address,
  output logic [8:0]  newadd,
  output logic        J,
  output logic        Br,
  output logic        Z,
  output logic        B
);
  datapath dp (.clk(clk), .rst(reset), .wb_data(WB_Data), .address(Address), .newadd(newadd),
               .j(J), .br(Br), .z(Z), .b(B));
endmodule

// File: tb/tb_riscv.sv
// tb_riscv: directed program exercising forwarding, load-use stall, branches, jumps and mid-run reset
module tb_riscv;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] WB_Data, Address;
  logic [8:0] newadd;
  logic J, Br, Z, B;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_wb [1:27];
  riscv dut (.clk(clk), .reset(reset), .WB_Data(WB_Data), .Address(Address), .newadd(newadd),
             .J(J), .Br(Br), .Z(Z), .B(B));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic put(input int a, input logic [31:0] v);
    dut.dp.instr_mem.Inst_mem[a / 4] = v;
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_addr"}, Address, 32'h0);
    check({tag, "_wb"}, WB_Data, 32'h0);
    check({tag, "_newadd"}, {23'b0, newadd}, 32'h0);
    check({tag, "_flags"}, {28'b0, J, Br, Z, B}, 32'h0);
  endtask
  initial begin
    for (int i = 0; i < 128; i++) dut.dp.instr_mem.Inst_mem[i] = '0;
    put(32'h00, 32'h00500093);
    put(32'h04, 32'h00700113);
    put(32'h08, 32'h002081B3);
    put(32'h0C, 32'h00302023);
    put(32'h10, 32'h00108463);
    put(32'h14, 32'h00100393);
    put(32'h18, 32'h00002203);
    put(32'h1C, 32'h004202B3);
    put(32'h20, 32'h0100036F);
    put(32'h24, 32'h00100413);
    put(32'h28, 32'h00100493);
    put(32'h2C, 32'h00100513);
    put(32'h30, 32'h00109463);
    put(32'h34, 32'h00900013);
    put(32'h38, 32'h401185B3);
    put(32'h3C, 32'h40208633);
    put(32'h40, 32'h00C0B6B3);
    put(32'h44, 32'h40165713);
    put(32'h48, 32'h123457B7);
    put(32'h4C, 32'h06000867);
    put(32'h50, 32'h00100A13);
    put(32'h54, 32'h00100A93);
    put(32'h60, 32'h00370893);
    for (int e = 1; e <= 27; e++) exp_wb[e] = '0;
    exp_wb[4] = 32'd5;
    exp_wb[5] = 32'd7;
    exp_wb[6] = 32'd12;
    exp_wb[11] = 32'd12;
    exp_wb[13] = 32'd24;
    exp_wb[14] = 32'h24;
    exp_wb[19] = 32'd7;
    exp_wb[20] = 32'hFFFFFFFE;
    exp_wb[21] = 32'd1;
    exp_wb[22] = 32'hFFFFFFFF;
    exp_wb[23] = 32'h12345000;
    exp_wb[24] = 32'h50;
    exp_wb[27] = 32'd2;
    #2 reset = 1'b1;
    #1 reset_checks("por");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    for (int e = 1; e <= 27; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("wb_e%0d", e), WB_Data, exp_wb[e]);
      if (e == 6) begin
        check("beq_flags", {28'b0, J, Br, Z, B}, 32'b0111);
        check("beq_newadd", {23'b0, newadd}, 32'h18);
      end
      if (e == 9 || e == 10) check($sformatf("stall_addr_e%0d", e), Address, 32'h20);
      if (e == 12) begin
        check("jal_flags", {29'b0, J, Br, B}, 32'b100);
        check("jal_newadd", {23'b0, newadd}, 32'h30);
      end
      if (e == 15) begin
        check("bne_flags", {28'b0, J, Br, Z, B}, 32'b0110);
        check("bne_addr", Address, 32'h38);
        check("bne_newadd", {23'b0, newadd}, 32'h3C);
      end
      if (e == 16) check("bne_noflush_addr", Address, 32'h3C);
      if (e == 22) begin
        check("jalr_flags", {29'b0, J, Br, B}, 32'b100);
        check("jalr_newadd", {23'b0, newadd}, 32'h60);
      end
      if (e == 23) check("jalr_addr", Address, 32'h60);
    end
    #3 reset = 1'b1;
    #1 reset_checks("mid");
    #4 reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("restart_wb_e%0d", e), WB_Data, exp_wb[e]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv.md
RISCV -- requirements
Module: riscv

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset; one clock, reset is asynchronous and active-high.
REQ-003 WB_Data  output  32  value being written to register file by WB stage this cycle (0 when no write).
REQ-004 Address  output  32  current fetch PC (byte address).
REQ-005 newadd  output  9  next-PC bits [8:0] selected this cycle (PC+4, branch target or jump target).
REQ-006 J  output  1  jump (JAL/JALR) resolved in EX this cycle.
REQ-007 Br  output  1  conditional branch instruction present in EX this cycle.
REQ-008 Z  output  1  EX-stage ALU result equals zero.
REQ-009 B  output  1  conditional branch taken in EX this cycle (Br AND condition true).

Function
REQ-010 Hierarchy SHALL contain datapath instance dp holding instruction-memory instance instr_mem with array Inst_mem: 128 x 32-bit words, indexed by PC[8:2], loadable by $readmemh, read combinationally.
REQ-011 Classic 5-stage pipeline SHALL be used: IF, ID, EX, MEM, WB, one instruction issued per cycle absent hazards.
REQ-012 Supported RV32I subset: LUI; ADD SUB AND OR XOR SLL SRL SRA SLT SLTU; ADDI ANDI ORI XORI SLTI SLLI SRLI SRAI; LW; SW; BEQ BNE BLT BGE; JAL; JALR. Other opcodes SHALL execute as NOP.
REQ-013 Register file: 32 x 32, x0 reads 0 and ignores writes; two read ports, one write port; WB write visible to ID read in same cycle (write-through bypass).
REQ-014 Data memory: 256 x 32-bit words, word-addressed by ALU result [9:2]; synchronous write in MEM, combinational read.
REQ-015 Forwarding SHALL supply EX operands from EX/MEM (priority) then MEM/WB when rd matches rs and rd != 0.
REQ-016 Load-use hazard (LW in EX, dependent instruction in ID) SHALL stall IF/ID one cycle and insert a bubble into EX.
REQ-017 Branches/jumps resolve in EX; when B or J asserts, PC loads target and IF/ID and ID/EX SHALL be flushed (2-cycle penalty).
REQ-018 Branch target = EX PC + sign-extended B-immediate; JAL = PC + J-immediate; JALR = (rs1+imm) with bit0 cleared; JAL/JALR write PC+4 to rd.
REQ-019 Arithmetic 32-bit wrap-around; shifts use operand[4:0]; SLT signed, SLTU unsigned; BLT/BGE signed.
REQ-020 PC wraps modulo instruction-memory size (PC[8:2] index); no trap on misaligned or out-of-range fetch.
REQ-021 Simultaneous stall and taken branch: flush SHALL win.

Reset
REQ-022 Reset assertion SHALL immediately force PC=0, all pipeline registers to bubble (NOP, no write, no branch), register file and data memory to 0.
REQ-023 During reset outputs: Address=0, WB_Data=0, newadd=0, J=Br=Z=B=0.
REQ-024 Inst_mem contents SHALL NOT be altered by reset.
REQ-025 First fetch from address 0 on first rising edge after reset deasserts; reset mid-operation discards all in-flight instructions.

Verification
REQ-026 ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2 -> WB_Data shows 5, 7, 12 in consecutive cycles from cycle 5 (forwarding, no stall).
REQ-027 SW x3,0(x0); LW x4,0(x0); ADD x5,x4,x4 -> one-cycle stall, WB_Data 24 for x5.
REQ-028 BEQ x1,x1,+8 at PC 0x10 -> Br=1, Z=1, B=1, newadd=0x18, next two fetched instructions produce no WB.
REQ-029 BNE x1,x1,+8 -> Br=1, B=0, newadd=PC+4, no flush.
REQ-030 JAL x6,+16 at PC 0x20 -> J=1, newadd=0x30, WB_Data=0x24 for x6; ADDI x0,x0,9 -> x0 stays 0.
REQ-031 Assert reset mid-program for 5 ns -> Address=0 immediately, all flags 0, execution restarts from PC 0.
